// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the ALU execute stage: ALU opcode encodings, datapath
// width, and the result-buffer state encodings.
// Pure declarations; no logic or timing.
// Not applicable: holds no handshake or flow control.
package alu_exec_stage_pkg;

  // Datapath width the ALU is built for.
  localparam int ALU_XLEN = 32;

  // ALU opcodes (shared parameter header).
  localparam int ALU_OP_LENGTH = 2;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADD = 2'd0;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_AND = 2'd1;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUB = 2'd2;

  // Occupancy of the two-entry result buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU: ADD / AND / SUB on ALU_XLEN-bit operands, modulo 2^ALU_XLEN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result is valid whenever the operands are.
// Ports: op (opcode), a / b (operands), result (ALU output; 0 for unused opcodes).
module alu_exec_stage_alu
  import alu_exec_stage_pkg::*;
(
  input  logic [ALU_OP_LENGTH-1:0] op,
  input  logic [ALU_XLEN-1:0]      a,
  input  logic [ALU_XLEN-1:0]      b,
  output logic [ALU_XLEN-1:0]      result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_OP_ADD: result = a + b;
      ALU_OP_AND: result = a & b;
      ALU_OP_SUB: result = a - b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: selects operands, runs the ALU, buffers results for writeback.
// Latency: 1 cycle from accept to out_* when the buffer is empty (or draining).
// Backpressure: 2-entry skid buffer; in_ready is registered and drops only when full.
// Ports:
//   clk, rst_n, flush                 clock, async active-low reset, sync buffer clear
//   in_valid/in_ready + in_*          decoded instruction in (opcode, rs1, rs2, imm, pc,
//                                     operand selects, rd, we)
//   out_valid/out_ready + out_*       result, rd and write enable to writeback
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int XLEN       = ALU_XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_OP_LENGTH-1:0] in_alu_op,
  input  logic [XLEN-1:0]          in_rs1,
  input  logic [XLEN-1:0]          in_rs2,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     in_src_a_sel,
  input  logic                     in_src_b_sel,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  input  logic                     in_we,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [REG_ADDR_W-1:0]    out_rd,
  output logic                     out_we
);

  // The ALU is fixed-width; a mismatched XLEN would silently truncate.
  if (XLEN != ALU_XLEN) begin : g_xlen_check
    $error("alu_exec_stage: XLEN must equal ALU_XLEN");
  end

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } entry_t;

  buf_state_t state_q, state_d;
  entry_t     head_q, skid_q, new_entry;
  logic       in_ready_q;

  logic            accept, pop;
  logic            load_head_new, load_skid_new, load_head_skid;
  logic [XLEN-1:0] op_a, op_b, alu_result;

  // Operand selection feeds the ALU directly.
  assign op_a = in_src_a_sel ? in_pc  : in_rs1;
  assign op_b = in_src_b_sel ? in_imm : in_rs2;

  alu_exec_stage_alu u_alu (
    .op     (in_alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result)
  );

  // Writes to x0 are suppressed here so writeback never has to check rd.
  assign new_entry.result = alu_result;
  assign new_entry.rd     = in_rd;
  assign new_entry.we     = in_we & (in_rd != '0);

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_we     = head_q.we;

  // Next state and buffer-load controls. flush wins over accept and pop;
  // loads are left low under flush so a same-cycle accept is dropped.
  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_skid_new  = 1'b0;
    load_head_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d       = ST_ONE;
            load_head_new = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_head_new = 1'b1;
          end else if (accept) begin
            state_d       = ST_FULL;
            load_skid_new = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered decode of the next state: keeps out_ready off the in_ready path.
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_new) begin
        head_q <= new_entry;
      end else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid_new) begin
        skid_q <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expected results.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [ALU_OP_LENGTH-1:0] in_alu_op;
  logic [XLEN-1:0]          in_rs1, in_rs2, in_imm, in_pc;
  logic                     in_src_a_sel, in_src_b_sel;
  logic [RW-1:0]            in_rd;
  logic                     in_we;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_result;
  logic [RW-1:0]            out_rd;
  logic                     out_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_op    (in_alu_op),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .in_pc        (in_pc),
    .in_src_a_sel (in_src_a_sel),
    .in_src_b_sel (in_src_b_sel),
    .in_rd        (in_rd),
    .in_we        (in_we),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_we       (out_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [ALU_OP_LENGTH-1:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic asel, input logic bsel, input logic [RW-1:0] rd,
                         input logic we);
    in_alu_op    = op;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_imm       = imm;
    in_pc        = pc;
    in_src_a_sel = asel;
    in_src_b_sel = bsel;
    in_rd        = rd;
    in_we        = we;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_ins(ALU_OP_ADD, 0, 0, 0, 0, 1'b0, 1'b0, '0, 1'b0);
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", 32'(out_rd), 0);
    check("rst_out_we", 32'(out_we), 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);

    // Single ADD rs1 + imm.
    out_ready = 1'b1;
    set_ins(ALU_OP_ADD, 4, 99, 3, 0, 1'b0, 1'b1, 5'd5, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 1);
    check("single_result", out_result, 7);
    check("single_rd", 32'(out_rd), 5);
    check("single_we", 32'(out_we), 1);
    tick();
    check("single_drained", 32'(out_valid), 0);

    // Back-pressure: fill both entries, offer a third, then drain in order.
    out_ready = 1'b0;
    set_ins(ALU_OP_SUB, 7, 3, 0, 0, 1'b0, 1'b0, 5'd1, 1'b1);
    in_valid = 1'b1;
    tick();
    check("bp_ready_one", 32'(in_ready), 1);
    set_ins(ALU_OP_AND, 32'hC, 32'hA, 0, 0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    check("bp_ready_full", 32'(in_ready), 0);
    check("bp_head_result", out_result, 4);
    check("bp_head_rd", 32'(out_rd), 1);
    set_ins(ALU_OP_ADD, 100, 1, 0, 0, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    check("bp_third_blocked", 32'(in_ready), 0);
    check("bp_hold_result", out_result, 4);
    set_ins(ALU_OP_SUB, 32'hDEAD, 32'hBEEF, 5, 7, 1'b1, 1'b1, 5'd9, 1'b0);
    tick();
    check("bp_hold_result2", out_result, 4);
    check("bp_hold_rd", 32'(out_rd), 1);
    check("bp_hold_valid", 32'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_second_result", out_result, 8);
    check("bp_second_rd", 32'(out_rd), 2);
    check("bp_ready_back", 32'(in_ready), 1);
    tick();
    check("bp_drained", 32'(out_valid), 0);

    // Streaming: one result per cycle, no bubbles.
    for (int i = 0; i < 10; i++) begin
      set_ins(ALU_OP_ADD, 0, 0, 32'(i), 32'h100, 1'b1, 1'b1, 5'd4, 1'b1);
      in_valid = 1'b1;
      tick();
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("stream_result_%0d", i), out_result, 32'h100 + 32'(i));
      check($sformatf("stream_ready_%0d", i), 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(out_valid), 0);

    // Wrap-around and x0 write suppression.
    set_ins(ALU_OP_ADD, 32'hFFFF_FFFF, 1, 0, 0, 1'b0, 1'b0, 5'd0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("x0_valid", 32'(out_valid), 1);
    check("x0_result", out_result, 0);
    check("x0_we", 32'(out_we), 0);
    check("x0_rd", 32'(out_rd), 0);
    tick();

    // Flush from FULL with in_valid and out_ready asserted in the flush cycle.
    out_ready = 1'b0;
    set_ins(ALU_OP_ADD, 1, 1, 0, 0, 1'b0, 1'b0, 5'd7, 1'b1);
    in_valid = 1'b1;
    tick();
    set_ins(ALU_OP_ADD, 2, 2, 0, 0, 1'b0, 1'b0, 5'd7, 1'b1);
    tick();
    check("fl_full", 32'(in_ready), 0);
    set_ins(ALU_OP_ADD, 3, 3, 0, 0, 1'b0, 1'b0, 5'd7, 1'b1);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid_cleared", 32'(out_valid), 0);
    check("fl_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_nothing_%0d", i), 32'(out_valid), 0);
    end

    // Flush in ONE state discards a same-cycle accepted instruction.
    out_ready = 1'b0;
    set_ins(ALU_OP_SUB, 10, 1, 0, 0, 1'b0, 1'b0, 5'd8, 1'b1);
    in_valid = 1'b1;
    tick();
    set_ins(ALU_OP_SUB, 20, 1, 0, 0, 1'b0, 1'b0, 5'd8, 1'b1);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("fl1_valid_cleared", 32'(out_valid), 0);
    tick();
    check("fl1_nothing", 32'(out_valid), 0);

    // Next instruction after flush flows normally.
    set_ins(ALU_OP_ADD, 5, 6, 0, 0, 1'b0, 1'b0, 5'd9, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_fl_valid", 32'(out_valid), 1);
    check("post_fl_result", out_result, 11);
    check("post_fl_rd", 32'(out_rd), 9);
    tick();
    check("post_fl_drained", 32'(out_valid), 0);

    // Asynchronous reset mid-stream while FULL.
    out_ready = 1'b0;
    set_ins(ALU_OP_ADD, 40, 2, 0, 0, 1'b0, 1'b0, 5'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("mid_full", 32'(in_ready), 0);
    check("mid_head", out_result, 42);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_we", 32'(out_we), 0);
    check("mid_rst_rd", 32'(out_rd), 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_still_empty", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
